// File: rtl/cam_mac_pkg.sv
// Shared types and default geometry for the CAM/MAC storage bank.
package cam_mac_pkg;

  typedef enum logic [1:0] {
    MODE_MAC    = 2'd0,
    MODE_CAM    = 2'd1,
    MODE_SWITCH = 2'd2
  } mode_e;

  localparam int DEF_ROWS    = 4;
  localparam int DEF_WORD_W  = 8;
  localparam int DEF_QUERY_W = 4;

  // Index width, kept at least 1 so a single-row bank still has a legal port.
  function automatic int calc_addr_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  localparam int DEF_ADDR_W = calc_addr_w(DEF_ROWS);

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over a per-row match vector.
module cam_prio_enc
  import cam_mac_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int IDX_W = calc_addr_w(ROWS)
) (
  input  logic [ROWS-1:0]  i_vec,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top so the lowest set bit is the last to win.
  always_comb begin
    o_hit = |i_vec;
    o_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      o_idx = i_vec[r] ? IDX_W'(r) : o_idx;
    end
  end

endmodule

// File: rtl/cam_mac_bank.sv
// Storage bank with MAC read/write mode and CAM key-search mode; every
// response is registered one cycle after the command.
module cam_mac_bank
  import cam_mac_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int QUERY_W = DEF_QUERY_W,
  localparam int ADDR_W = calc_addr_w(ROWS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_mac_en,
  input  logic              i_w_en,
  input  logic              i_read_bar,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_word,
  input  logic [QUERY_W-1:0] i_query,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic [ROWS-1:0]   o_match,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_hit_idx,
  output logic              o_mvalid,
  output logic              o_busy
);

  mode_e             r_state;
  mode_e             w_next;
  logic [WORD_W-1:0] r_mem [ROWS];
  logic              r_rvalid, r_mvalid, r_hit, r_busy;
  logic [WORD_W-1:0] r_rdata;
  logic [ROWS-1:0]   r_match;
  logic [ADDR_W-1:0] r_hit_idx;

  logic              w_do_write, w_do_read, w_do_search;
  logic              w_addr_ok;
  logic [WORD_W-1:0] w_rd_word, w_rd_data;
  logic [ROWS-1:0]   w_match;
  logic              w_hit;
  logic [ADDR_W-1:0] w_hit_idx;

  // Mode sequencing: any disagreement between mode and MAC_en costs one settle cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MODE_MAC:    w_next = i_mac_en ? MODE_MAC : MODE_SWITCH;
      MODE_CAM:    w_next = i_mac_en ? MODE_SWITCH : MODE_CAM;
      MODE_SWITCH: w_next = i_mac_en ? MODE_MAC : MODE_CAM;
      default:     w_next = i_mac_en ? MODE_MAC : MODE_CAM;
    endcase
  end

  // Commands only fire when the mode is settled and agrees with MAC_en.
  always_comb begin
    w_do_write  = i_cs && (r_state == MODE_MAC) && i_mac_en && i_w_en;
    w_do_read   = i_cs && (r_state == MODE_MAC) && i_mac_en && !i_w_en;
    w_do_search = i_cs && (r_state == MODE_CAM) && !i_mac_en;
  end

  // Row read mux and per-row key compare; unmatched addresses read as zero.
  always_comb begin
    w_rd_word = '0;
    w_addr_ok = 1'b0;
    w_match   = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_rd_word  = (i_addr == ADDR_W'(r)) ? r_mem[r] : w_rd_word;
      w_addr_ok  = w_addr_ok | (i_addr == ADDR_W'(r));
      w_match[r] = (r_mem[r][QUERY_W-1:0] == i_query);
    end
    if (w_addr_ok) begin
      w_rd_data = i_read_bar ? ~w_rd_word : w_rd_word;
    end else begin
      w_rd_data = '0;
    end
  end

  cam_prio_enc #(.ROWS(ROWS), .IDX_W(ADDR_W)) u_prio (
    .i_vec (w_match),
    .o_hit (w_hit),
    .o_idx (w_hit_idx)
  );

  // State register; reset lands directly in the mode MAC_en asks for.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= i_mac_en ? MODE_MAC : MODE_CAM;
    end else begin
      r_state <= w_next;
    end
  end

  // Storage array.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < ROWS; r++) r_mem[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_do_write && (i_addr == ADDR_W'(r))) r_mem[r] <= i_word;
      end
    end
  end

  // Output registers: pulses every cycle, data/results hold until replaced.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_match   <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_mvalid  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rvalid <= w_do_read;
      r_mvalid <= w_do_search;
      r_busy   <= (w_next == MODE_SWITCH);
      if (w_do_read) r_rdata <= w_rd_data;
      if (w_do_search) begin
        r_match   <= w_match;
        r_hit     <= w_hit;
        r_hit_idx <= w_hit_idx;
      end
    end
  end

  assign o_rdata   = r_rdata;
  assign o_rvalid  = r_rvalid;
  assign o_match   = r_match;
  assign o_hit     = r_hit;
  assign o_hit_idx = r_hit_idx;
  assign o_mvalid  = r_mvalid;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_cam_mac_bank.sv
// Directed self-checking bench for cam_mac_bank.
module tb_cam_mac_bank;
  import cam_mac_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst, cs, mac_en, w_en, read_bar;
  logic [DEF_ADDR_W-1:0] addr;
  logic [DEF_WORD_W-1:0] word;
  logic [DEF_QUERY_W-1:0] query;
  logic [DEF_WORD_W-1:0] rdata;
  logic                  rvalid, hit, mvalid, busy;
  logic [DEF_ROWS-1:0]   match;
  logic [DEF_ADDR_W-1:0] hit_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cam_mac_bank dut (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_mac_en(mac_en), .i_w_en(w_en),
    .i_read_bar(read_bar), .i_addr(addr), .i_word(word), .i_query(query),
    .o_rdata(rdata), .o_rvalid(rvalid), .o_match(match), .o_hit(hit),
    .o_hit_idx(hit_idx), .o_mvalid(mvalid), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_rdata"},  32'(rdata),   32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid),  32'h0);
    chk({tag, "_match"},  32'(match),   32'h0);
    chk({tag, "_hit"},    32'(hit),     32'h0);
    chk({tag, "_idx"},    32'(hit_idx), 32'h0);
    chk({tag, "_mvalid"}, 32'(mvalid),  32'h0);
    chk({tag, "_busy"},   32'(busy),    32'h0);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; mac_en = 1'b1; w_en = 1'b0; read_bar = 1'b0;
    addr = 2'd0; word = 8'h00; query = 4'h0;
    tick();
    tick();
    chk_cleared("reset");

    // MAC writes row0=01, row1=07
    rst = 1'b0; cs = 1'b1; w_en = 1'b1; addr = 2'd0; word = 8'h01;
    tick();
    chk("wr0_rvalid", 32'(rvalid), 32'h0);
    addr = 2'd1; word = 8'h07;
    tick();
    chk("wr1_rvalid", 32'(rvalid), 32'h0);

    // Back-to-back reads, Q and QB
    w_en = 1'b0; addr = 2'd0; read_bar = 1'b0;
    tick();
    chk("rd0_data", 32'(rdata), 32'h01);
    chk("rd0_valid", 32'(rvalid), 32'h1);
    read_bar = 1'b1;
    tick();
    chk("rd0b_data", 32'(rdata), 32'hFE);
    chk("rd0b_valid", 32'(rvalid), 32'h1);
    addr = 2'd1; read_bar = 1'b0;
    tick();
    chk("rd1_data", 32'(rdata), 32'h07);
    chk("rd1_valid", 32'(rvalid), 32'h1);

    // CS=0 read: no pulse, rdata holds
    cs = 1'b0; addr = 2'd0;
    tick();
    chk("cs0rd_valid", 32'(rvalid), 32'h0);
    chk("cs0rd_hold", 32'(rdata), 32'h07);

    // Switch to CAM; search presented during settle is dropped
    cs = 1'b1; mac_en = 1'b0; query = 4'h7;
    tick();
    chk("sw_busy", 32'(busy), 32'h1);
    chk("sw_mvalid", 32'(mvalid), 32'h0);
    tick();
    chk("sw_busy_end", 32'(busy), 32'h0);
    chk("sw_mvalid2", 32'(mvalid), 32'h0);
    chk("sw_match_idle", 32'(match), 32'h0);

    tick();
    chk("q7_match", 32'(match), 32'h2);
    chk("q7_hit", 32'(hit), 32'h1);
    chk("q7_idx", 32'(hit_idx), 32'h1);
    chk("q7_mvalid", 32'(mvalid), 32'h1);
    query = 4'h3;
    tick();
    chk("q3_match", 32'(match), 32'h0);
    chk("q3_hit", 32'(hit), 32'h0);
    chk("q3_idx", 32'(hit_idx), 32'h0);
    chk("q3_mvalid", 32'(mvalid), 32'h1);
    query = 4'h0;
    tick();
    chk("q0_match", 32'(match), 32'hC);
    chk("q0_hit", 32'(hit), 32'h1);
    chk("q0_idx", 32'(hit_idx), 32'h2);
    query = 4'hF;
    tick();
    chk("qF_hit", 32'(hit), 32'h0);
    chk("qF_match", 32'(match), 32'h0);

    // w_en in CAM mode must not write; search still runs
    w_en = 1'b1; addr = 2'd0; word = 8'hAA; query = 4'h1;
    tick();
    chk("camwr_match", 32'(match), 32'h1);
    chk("camwr_idx", 32'(hit_idx), 32'h0);
    chk("camwr_hit", 32'(hit), 32'h1);

    // CS=0 search: no pulse, results hold
    w_en = 1'b0; cs = 1'b0; query = 4'h7;
    tick();
    chk("cs0q_mvalid", 32'(mvalid), 32'h0);
    chk("cs0q_match", 32'(match), 32'h1);
    chk("cs0q_hit", 32'(hit), 32'h1);

    // Return to MAC
    cs = 1'b1; mac_en = 1'b1; addr = 2'd0;
    tick();
    chk("tomac_busy", 32'(busy), 32'h1);
    chk("tomac_rvalid", 32'(rvalid), 32'h0);
    tick();
    chk("tomac_busy_end", 32'(busy), 32'h0);
    chk("tomac_rvalid2", 32'(rvalid), 32'h0);
    tick();
    chk("camwr_row0", 32'(rdata), 32'h01);
    chk("camwr_row0_v", 32'(rvalid), 32'h1);

    w_en = 1'b1; addr = 2'd2; word = 8'h33;
    tick();
    w_en = 1'b0; read_bar = 1'b1;
    tick();
    chk("rd2b_data", 32'(rdata), 32'hCC);
    chk("rd2b_valid", 32'(rvalid), 32'h1);

    // Reset during SWITCH, landing in CAM
    read_bar = 1'b0; mac_en = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    chk_cleared("rst_sw");
    rst = 1'b0; query = 4'h0;
    tick();
    chk("post_rst_cam_match", 32'(match), 32'hF);
    chk("post_rst_cam_mvalid", 32'(mvalid), 32'h1);

    // Back to MAC, then reset concurrently with a read
    mac_en = 1'b1;
    tick();
    tick();
    addr = 2'd1;
    tick();
    chk("pre_rst_rd", 32'(rdata), 32'h00);
    chk("pre_rst_rdv", 32'(rvalid), 32'h1);
    rst = 1'b1;
    tick();
    chk_cleared("rst_rd");
    rst = 1'b0;
    for (int r = 0; r < DEF_ROWS; r++) begin
      addr = DEF_ADDR_W'(r);
      tick();
      chk("rst_rows_data", 32'(rdata), 32'h00);
      chk("rst_rows_valid", 32'(rvalid), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
